mmio_io_hub: RTL and testbench

Parametrised memory-mapped I/O hub that replaces the fixed KEY/SW/HEX/LEDR I/O path of the single-cycle processor top level. It decodes processor load/store addresses, returns registered read data, debounces switches, synchronises keys, latches change events with ready/overrun status, drives LEDs and seven-segment digits, and raises a level interrupt. It sits between the processor's address/store-data path and the board pins, alongside the data-memory controller.

---
 rtl/io_hub_pkg.sv | 80 ++++++++
 rtl/seven_seg.sv | 11 +
 rtl/mmio_io_hub.sv | 165 ++++++++++++++++
 tb/tb_mmio_io_hub.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/io_hub_pkg.sv
// Shared definitions for the MMIO I/O hub: default register map, control/status
// bit layout, the control-register update rule and the seven-segment table.
package io_hub_pkg;

    localparam logic [31:0] IO_ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] IO_ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] IO_ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] IO_ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] IO_ADDR_TCNT  = 32'hF000_0020;
    localparam logic [31:0] IO_ADDR_TLIM  = 32'hF000_0024;
    localparam logic [31:0] IO_ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] IO_ADDR_SCTRL = 32'hF000_0114;
    localparam logic [31:0] IO_ADDR_TCTL  = 32'hF000_0120;

    localparam int CTRL_RDY = 0;
    localparam int CTRL_OVR = 2;
    localparam int CTRL_IE  = 4;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } ctrl_t;

    function automatic logic [4:0] ctrl_word(input ctrl_t c);
        logic [4:0] w;
        w = '0;
        w[CTRL_IE]  = c.ie;
        w[CTRL_OVR] = c.ovr;
        w[CTRL_RDY] = c.rdy;
        return w;
    endfunction

    // A new event always wins over a same-cycle clear; overrun only flags an
    // event that lands on a ready nobody consumed.
    function automatic ctrl_t ctrl_next(input ctrl_t c, input logic evt, input logic rd_clr,
                                        input logic wr, input logic [4:0] wd,
                                        input logic rdy_writable);
        ctrl_t n;
        n = c;
        if (wr) begin
            n.ie = wd[CTRL_IE];
            if (!wd[CTRL_OVR]) n.ovr = 1'b0;
            if (rdy_writable && !wd[CTRL_RDY]) n.rdy = 1'b0;
        end
        if (rd_clr) n.rdy = 1'b0;
        if (evt) begin
            if (c.rdy && !rd_clr) n.ovr = 1'b1;
            n.rdy = 1'b1;
        end
        return n;
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg.sv
// One hexadecimal digit: 4-bit nibble to 7 active-low segments.
module seven_seg
    import io_hub_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = seg_decode(nib);

endmodule

// File: rtl/mmio_io_hub.sv
// Memory-mapped board I/O hub: KEY/SW inputs with event status, LEDR/HEX outputs, irq.
// Optional interval timer (TCNT/TLIM/TCTL) enabled by defining IO_HUB_TIMER_EN.
module mmio_io_hub
    import io_hub_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int KEY_BITS        = 4,
    parameter int SW_BITS         = 10,
    parameter int LEDR_BITS       = 10,
    parameter int HEX_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0] ADDR_HEX   = DBITS'(IO_ADDR_HEX),
    parameter logic [DBITS-1:0] ADDR_LEDR  = DBITS'(IO_ADDR_LEDR),
    parameter logic [DBITS-1:0] ADDR_KEY   = DBITS'(IO_ADDR_KEY),
    parameter logic [DBITS-1:0] ADDR_SW    = DBITS'(IO_ADDR_SW),
    parameter logic [DBITS-1:0] ADDR_KCTRL = DBITS'(IO_ADDR_KCTRL),
    parameter logic [DBITS-1:0] ADDR_SCTRL = DBITS'(IO_ADDR_SCTRL)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBITS-1:0]        addr,
    input  logic [DBITS-1:0]        wdata,
    input  logic                    we,
    input  logic                    re,
    output logic [DBITS-1:0]        rdata,
    output logic                    hit,
    input  logic [KEY_BITS-1:0]     key_in,
    input  logic [SW_BITS-1:0]      sw_in,
    output logic [LEDR_BITS-1:0]    ledr_out,
    output logic [7*HEX_DIGITS-1:0] hex_out,
    output logic                    irq
);

    localparam int          DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DB = DEBOUNCE_CYCLES;

    logic [HEX_DIGITS-1:0][3:0] hex_q;
    logic [LEDR_BITS-1:0]       ledr_q;
    logic [KEY_BITS-1:0]        key_s1, key_s2, kdata;
    logic [SW_BITS-1:0]         sw_s1, sw_s2, sdata;
    logic [DW-1:0]              sw_cnt;
    ctrl_t                      kctrl, sctrl;
    logic                       key_evt, sw_load, tmr_irq;
    logic                       rd_hit;
    logic [DBITS-1:0]           rd_val;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata};

    wire acc_hex   = (addr == ADDR_HEX);
    wire acc_ledr  = (addr == ADDR_LEDR);
    wire acc_key   = (addr == ADDR_KEY);
    wire acc_sw    = (addr == ADDR_SW);
    wire acc_kctrl = (addr == ADDR_KCTRL);
    wire acc_sctrl = (addr == ADDR_SCTRL);

    // Keys are inverted ahead of the synchroniser so that a cleared flop means
    // "not pressed" and leaving reset with keys idle raises no event.
    assign key_evt = (key_s2 != kdata);
    // The candidate has held its value for sw_cnt+1 cycles at this edge.
    assign sw_load = (sw_s2 != sdata) && ((32'(sw_cnt) + 32'd1) >= DB);

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_s1 <= '0;
            key_s2 <= '0;
            kdata  <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            sdata  <= '0;
            sw_cnt <= '0;
            kctrl  <= '0;
            sctrl  <= '0;
            hex_q  <= '0;
            ledr_q <= '0;
        end else begin
            key_s1 <= ~key_in;
            key_s2 <= key_s1;
            kdata  <= key_s2;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
            if (sw_s1 != sw_s2)
                sw_cnt <= '0;
            else if (32'(sw_cnt) < DB)
                sw_cnt <= sw_cnt + DW'(1);
            if (sw_load) sdata <= sw_s2;
            kctrl <= ctrl_next(kctrl, key_evt, re && acc_key, we && acc_kctrl, wdata[4:0], 1'b0);
            sctrl <= ctrl_next(sctrl, sw_load, re && acc_sw, we && acc_sctrl, wdata[4:0], 1'b0);
            if (we && acc_hex)  hex_q  <= wdata[4*HEX_DIGITS-1:0];
            if (we && acc_ledr) ledr_q <= wdata[LEDR_BITS-1:0];
        end
    end

`ifdef IO_HUB_TIMER_EN
    localparam logic [DBITS-1:0] ADDR_TCNT = DBITS'(IO_ADDR_TCNT);
    localparam logic [DBITS-1:0] ADDR_TLIM = DBITS'(IO_ADDR_TLIM);
    localparam logic [DBITS-1:0] ADDR_TCTL = DBITS'(IO_ADDR_TCTL);

    logic [DBITS-1:0] tcnt, tlim;
    ctrl_t            tctrl;
    logic             tmr_evt;

    wire acc_tcnt = (addr == ADDR_TCNT);
    wire acc_tlim = (addr == ADDR_TLIM);
    wire acc_tctl = (addr == ADDR_TCTL);

    assign tmr_evt = (tlim != '0) && (tcnt == tlim - DBITS'(1));
    assign tmr_irq = tctrl.rdy & tctrl.ie;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt  <= '0;
            tlim  <= '0;
            tctrl <= '0;
        end else begin
            if (we && acc_tcnt)  tcnt <= wdata;
            else if (tmr_evt)    tcnt <= '0;
            else                 tcnt <= tcnt + DBITS'(1);
            if (we && acc_tlim)  tlim <= wdata;
            tctrl <= ctrl_next(tctrl, tmr_evt, 1'b0, we && acc_tctl, wdata[4:0], 1'b1);
        end
    end
`else
    assign tmr_irq = 1'b0;
`endif

    always_comb begin
        rd_hit = 1'b1;
        rd_val = '0;
        if (acc_hex)        rd_val = DBITS'(hex_q);
        else if (acc_ledr)  rd_val = DBITS'(ledr_q);
        else if (acc_key)   rd_val = DBITS'(kdata);
        else if (acc_sw)    rd_val = DBITS'(sdata);
        else if (acc_kctrl) rd_val = DBITS'(ctrl_word(kctrl));
        else if (acc_sctrl) rd_val = DBITS'(ctrl_word(sctrl));
`ifdef IO_HUB_TIMER_EN
        else if (acc_tcnt)  rd_val = tcnt;
        else if (acc_tlim)  rd_val = tlim;
        else if (acc_tctl)  rd_val = DBITS'(ctrl_word(tctrl));
`endif
        else                rd_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
            hit   <= 1'b0;
            irq   <= 1'b0;
        end else begin
            rdata <= re ? rd_val : '0;
            hit   <= (re || we) && rd_hit;
            irq   <= (kctrl.rdy & kctrl.ie) | (sctrl.rdy & sctrl.ie) | tmr_irq;
        end
    end

    assign ledr_out = ledr_q;

    for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_seg
        seven_seg u_seg (
            .nib (hex_q[i]),
            .seg (hex_out[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub with a short debounce window.
module tb_mmio_io_hub;

    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_KEY   = 32'hF000_0010;
    localparam logic [31:0] A_SW    = 32'hF000_0014;
    localparam logic [31:0] A_TCNT  = 32'hF000_0020;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we, re, hit, irq;
    logic [3:0]  key_in;
    logic [9:0]  sw_in, ledr_out;
    logic [41:0] hex_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mmio_io_hub #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .hit      (hit),
        .key_in   (key_in),
        .sw_in    (sw_in),
        .ledr_out (ledr_out),
        .hex_out  (hex_out),
        .irq      (irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        key_in = 4'hF; sw_in = '0;
        tick(2);
        chk("rst_ledr", 64'(ledr_out), 64'h0);
        chk("rst_hex", 64'(hex_out), 64'({6{7'h40}}));
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_hit", 64'(hit), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        reset = 1'b1;
        tick();
        rd(A_KCTRL);
        chk("kctrl_rst", 64'(rdata), 64'h0);
        chk("kctrl_hit", 64'(hit), 64'h1);

        wr(A_LEDR, 32'h0000_02A5);
        wr(A_HEX, 32'h00AB_CDEF);
        tick();
        chk("ledr_out", 64'(ledr_out), 64'h2A5);
        chk("hex_out", 64'(hex_out), 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
        rd(A_LEDR);
        chk("ledr_rd", 64'(rdata), 64'h2A5);
        rd(A_HEX);
        chk("hex_rd", 64'(rdata), 64'hAB_CDEF);

        // Simultaneous store and load: read returns the pre-write value.
        addr = A_LEDR; wdata = 32'h155; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        chk("rw_old", 64'(rdata), 64'h2A5);
        tick();
        chk("rw_new", 64'(ledr_out), 64'h155);

        rd(32'hF000_0008);
        chk("unmap_hit", 64'(hit), 64'h0);
        chk("unmap_rdata", 64'(rdata), 64'h0);
        wr(A_KEY, 32'hF);
        rd(A_KEY);
        chk("kdata_ro", 64'(rdata), 64'h0);

        // Switch glitch of 3 cycles is rejected; the held value lands after 2+4 cycles.
        sw_in = 10'h001;
        tick(3);
        sw_in = 10'h000;
        tick();
        sw_in = 10'h001;
        addr = A_SCTRL; re = 1'b1;
        tick(6);
        chk("sw_early", 64'(rdata), 64'h0);
        tick();
        chk("sctrl_ready", 64'(rdata), 64'h01);
        re = 1'b0;
        rd(A_SW);
        chk("sdata", 64'(rdata), 64'h001);
        rd(A_SCTRL);
        chk("sctrl_clr", 64'(rdata), 64'h0);

        // Key press reaches ready at the third edge; second change flags overrun.
        key_in = 4'b1110;
        addr = A_KCTRL; re = 1'b1;
        tick(3);
        chk("key_lat", 64'(rdata), 64'h0);
        tick();
        chk("kctrl_ready", 64'(rdata), 64'h01);
        key_in = 4'hF;
        tick(4);
        chk("kctrl_ovr", 64'(rdata), 64'h05);
        re = 1'b0;
        wr(A_KCTRL, 32'h0);
        rd(A_KCTRL);
        chk("ovr_clr", 64'(rdata), 64'h01);
        rd(A_KEY);
        chk("kdata_rel", 64'(rdata), 64'h0);
        rd(A_KCTRL);
        chk("rdy_clr", 64'(rdata), 64'h0);

        // Interrupt: one cycle after ready, dropped one cycle after the KDATA read.
        wr(A_KCTRL, 32'h10);
        rd(A_KCTRL);
        chk("ie_rd", 64'(rdata), 64'h10);
        key_in = 4'b1101;
        tick(3);
        chk("irq_pre", 64'(irq), 64'h0);
        tick();
        chk("irq_set", 64'(irq), 64'h1);
        rd(A_KEY);
        chk("kdata_key1", 64'(rdata), 64'h2);
        chk("irq_hold", 64'(irq), 64'h1);
        tick();
        chk("irq_drop", 64'(irq), 64'h0);

`ifdef IO_HUB_TIMER_EN
        wr(32'hF000_0024, 32'd5);
        wr(A_TCNT, 32'd0);
        tick(5);
        rd(32'hF000_0120);
        chk("tctl_ready", 64'(rdata), 64'h01);
        rd(A_TCNT);
        chk("tcnt_wrap", 64'(rdata), 64'h1);
`else
        rd(A_TCNT);
        chk("tcnt_hit", 64'(hit), 64'h0);
        chk("tcnt_rdata", 64'(rdata), 64'h0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
